set_vars_tx: RTL and testbench

Serial transmitter for the neuron parameter-load link. It captures an 8-bit tau, weight and threshold in parallel and shifts them out LSB-first on three serial lines (expd, w, t), framed by the set_vars strobe. It sits on the host/config side and drives the set_vars receiver in the neuron core. The falling edge of set_vars commits the frame in the receiver.

---
 rtl/set_vars_tx.sv | 173 +++++++++++++++++
 tb/tb_set_vars_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/set_vars_tx.sv
// set_vars_tx: serial transmitter for the neuron parameter-load link.
// Captures tau/weight/threshold on an accepted start. Sends a one-cycle
// preamble with set_vars high, then WIDTH bits LSB-first on expd/w/t.
// Ends with a GAP_CYCLES-long low gap on set_vars. All outputs are registered.
module set_vars_tx #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] tau_in,
  input  logic [WIDTH-1:0] weight_in,
  input  logic [WIDTH-1:0] threshold_in,
  output logic             set_vars,
  output logic             expd,
  output logic             w,
  output logic             t,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [WIDTH-1:0] tau_q, tau_d;
  logic [WIDTH-1:0] wgt_q, wgt_d;
  logic [WIDTH-1:0] thr_q, thr_d;
  logic             set_vars_q, set_vars_d;
  logic             expd_q, expd_d;
  logic             w_q, w_d;
  logic             t_q, t_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] idx_nx_s;

  // idx_q is the bit currently on the data lines; idx_nx_s is the next one.
  assign idx_nx_s = idx_q + IDX_W'(1);

  // Next-state, shadow capture and registered-output computation.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    tau_d      = tau_q;
    wgt_d      = wgt_q;
    thr_d      = thr_q;
    set_vars_d = 1'b0;
    expd_d     = 1'b0;
    w_d        = 1'b0;
    t_d        = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          tau_d      = tau_in;
          wgt_d      = weight_in;
          thr_d      = threshold_in;
          idx_d      = {IDX_W{1'b0}};
          state_d    = PRE;
          set_vars_d = 1'b1;
          busy_d     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      PRE: begin
        // Preamble slot is on the lines now; drive bit 0 next.
        state_d    = SHIFT;
        idx_d      = {IDX_W{1'b0}};
        set_vars_d = 1'b1;
        busy_d     = 1'b1;
        expd_d     = tau_q[0];
        w_d        = wgt_q[0];
        t_d        = thr_q[0];
      end
      SHIFT: begin
        busy_d = 1'b1;
        if (idx_q == IDX_LAST) begin
          // Last bit has been on the lines for a full cycle: drop set_vars.
          state_d = GAP;
          idx_d   = {IDX_W{1'b0}};
          gap_d   = GAP_LOAD;
          done_d  = 1'b1;
        end else begin
          idx_d      = idx_nx_s;
          set_vars_d = 1'b1;
          expd_d     = tau_q[idx_nx_s];
          w_d        = wgt_q[idx_nx_s];
          t_d        = thr_q[idx_nx_s];
        end
      end
      GAP: begin
        if (gap_q <= GAP_W'(1)) begin
          // Gap ends on this edge; a pending start is taken right away so
          // held-high start yields exactly GAP_CYCLES low cycles.
          gap_d = {GAP_W{1'b0}};
          if (start) begin
            tau_d      = tau_in;
            wgt_d      = weight_in;
            thr_d      = threshold_in;
            idx_d      = {IDX_W{1'b0}};
            state_d    = PRE;
            set_vars_d = 1'b1;
            busy_d     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d  = gap_q - GAP_W'(1);
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = {IDX_W{1'b0}};
        gap_d   = {GAP_W{1'b0}};
      end
    endcase
  end

  // State, shadow and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= {IDX_W{1'b0}};
      gap_q      <= {GAP_W{1'b0}};
      tau_q      <= {WIDTH{1'b0}};
      wgt_q      <= {WIDTH{1'b0}};
      thr_q      <= {WIDTH{1'b0}};
      set_vars_q <= 1'b0;
      expd_q     <= 1'b0;
      w_q        <= 1'b0;
      t_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      tau_q      <= tau_d;
      wgt_q      <= wgt_d;
      thr_q      <= thr_d;
      set_vars_q <= set_vars_d;
      expd_q     <= expd_d;
      w_q        <= w_d;
      t_q        <= t_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign set_vars = set_vars_q;
  assign expd     = expd_q;
  assign w        = w_q;
  assign t        = t_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_set_vars_tx.sv
// Directed bench for set_vars_tx: an 8-bit/gap-1 instance and a 4-bit/gap-3 instance.
module tb_set_vars_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tau_in = 8'h00, weight_in = 8'h00, threshold_in = 8'h00;
  logic       set_vars, expd, w, t, busy, done;

  logic       start2 = 1'b0;
  logic [3:0] tau2 = 4'h0, weight2 = 4'h0, thr2 = 4'h0;
  logic       set_vars2, expd2, w2, t2, busy2, done2;

  int compared = 0;
  int mismatched = 0;

  // Observations per edge k+c, packed as {set_vars, expd, w, t, done, busy}.
  logic [5:0] obs_h [14];

  // Expected frame for tau=A5, weight=3C, threshold=81 (hand-derived).
  logic [5:0] exp_frame [14] = '{
    6'b100001, // k   preamble
    6'b110101, // k+1 bit0: e1 w0 t1
    6'b100001, // k+2 bit1: e0 w0 t0
    6'b111001, // k+3 bit2: e1 w1 t0
    6'b101001, // k+4 bit3: e0 w1 t0
    6'b101001, // k+5 bit4: e0 w1 t0
    6'b111001, // k+6 bit5: e1 w1 t0
    6'b100001, // k+7 bit6: e0 w0 t0
    6'b110101, // k+8 bit7: e1 w0 t1
    6'b000011, // k+9 set_vars falls, done
    6'b000000, // k+10 busy low
    6'b000000,
    6'b000000,
    6'b000000
  };

  // WIDTH=4, GAP=3 frame for tau=9, weight=6, threshold=0.
  logic [5:0] exp_p [10] = '{
    6'b100001, 6'b110001, 6'b101001, 6'b101001, 6'b110001,
    6'b000011, 6'b000001, 6'b000001, 6'b000000, 6'b000000
  };

  set_vars_tx #(.WIDTH(8), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .tau_in(tau_in), .weight_in(weight_in), .threshold_in(threshold_in),
    .set_vars(set_vars), .expd(expd), .w(w), .t(t), .busy(busy), .done(done)
  );

  set_vars_tx #(.WIDTH(4), .GAP_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .tau_in(tau2), .weight_in(weight2), .threshold_in(thr2),
    .set_vars(set_vars2), .expd(expd2), .w(w2), .t(t2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Records n edges starting at the accept edge; caller raises start beforehand.
  task automatic record(input int n, input logic hold, input logic pulses, input logic change);
    for (int c = 0; c < n; c++) begin
      tick();
      obs_h[c] = {set_vars, expd, w, t, done, busy};
      if (change && c == 0) begin
        tau_in = 8'hFF; weight_in = 8'hFF; threshold_in = 8'hFF;
      end
      start = hold | (pulses & ((c == 2) | (c == 8)));
    end
  endtask

  task automatic test_reset();
    #12;
    compared++;
    if ({set_vars, expd, w, t, done, busy} !== 6'b000000) begin
      mismatched++;
      $display("FAIL reset_dut got %b expected 000000", {set_vars, expd, w, t, done, busy});
    end
    compared++;
    if ({set_vars2, expd2, w2, t2, done2, busy2} !== 6'b000000) begin
      mismatched++;
      $display("FAIL reset_dut2 got %b expected 000000", {set_vars2, expd2, w2, t2, done2, busy2});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    tau_in = 8'hA5; weight_in = 8'h3C; threshold_in = 8'h81;
    start = 1'b1;
    record(14, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 14; c++) begin
      compared++;
      if (obs_h[c] !== exp_frame[c]) begin
        mismatched++;
        $display("FAIL basic_edge_k+%0d got %b expected %b", c, obs_h[c], exp_frame[c]);
      end
    end
  endtask

  task automatic test_input_hold();
    tau_in = 8'hA5; weight_in = 8'h3C; threshold_in = 8'h81;
    start = 1'b1;
    record(14, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 14; c++) begin
      compared++;
      if (obs_h[c] !== exp_frame[c]) begin
        mismatched++;
        $display("FAIL hold_edge_k+%0d got %b expected %b", c, obs_h[c], exp_frame[c]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    tau_in = 8'hA5; weight_in = 8'h3C; threshold_in = 8'h81;
    start = 1'b1;
    record(14, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 14; c++) begin
      compared++;
      if (obs_h[c] !== exp_frame[c]) begin
        mismatched++;
        $display("FAIL ignore_edge_k+%0d got %b expected %b", c, obs_h[c], exp_frame[c]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    tau_in = 8'h5A; weight_in = 8'hC3; threshold_in = 8'h18;
    start = 1'b1;
    record(5, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    compared++;
    if ({set_vars, expd, w, t, done, busy} !== 6'b000000) begin
      mismatched++;
      $display("FAIL midframe_reset got %b expected 000000", {set_vars, expd, w, t, done, busy});
    end
    tick();
    @(negedge clk);
    rst = 1'b1;
    tau_in = 8'hA5; weight_in = 8'h3C; threshold_in = 8'h81;
    start = 1'b1;
    record(14, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 14; c++) begin
      compared++;
      if (obs_h[c] !== exp_frame[c]) begin
        mismatched++;
        $display("FAIL after_reset_edge_k+%0d got %b expected %b", c, obs_h[c], exp_frame[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_v [3] = '{8'h01, 8'h80, 8'hFF};
    logic [7:0] re, rw, rt;
    logic [7:0] got_e [3], got_w [3], got_t [3];
    int hr [3], lr [2];
    int rbit = 0, nfr = 0, highrun = 0, lowrun = 0;
    logic prev = 1'b0;
    re = 8'h00; rw = 8'h00; rt = 8'h00;
    for (int i = 0; i < 3; i++) begin
      got_e[i] = 8'h00; got_w[i] = 8'h00; got_t[i] = 8'h00; hr[i] = 0;
    end
    lr[0] = 0; lr[1] = 0;
    tau_in = 8'h01; weight_in = 8'h01; threshold_in = 8'h01;
    start = 1'b1;
    for (int c = 0; c < 34; c++) begin
      tick();
      if (c == 0)  begin tau_in = 8'h80; weight_in = 8'h80; threshold_in = 8'h80; end
      if (c == 10) begin tau_in = 8'hFF; weight_in = 8'hFF; threshold_in = 8'hFF; end
      if (c == 20) start = 1'b0;
      // Receiver model: rising edge is the clear slot, then one bit per cycle.
      if (set_vars && !prev) begin
        rbit = 0; re = 8'h00; rw = 8'h00; rt = 8'h00; highrun = 0;
        if (nfr > 0 && nfr < 3) lr[nfr-1] = lowrun;
      end else if (set_vars) begin
        if (rbit < 8) begin
          re[rbit] = expd; rw[rbit] = w; rt[rbit] = t;
        end
        rbit++;
      end
      if (set_vars) highrun++;
      if (!set_vars && prev) begin
        if (nfr < 3) begin
          got_e[nfr] = re; got_w[nfr] = rw; got_t[nfr] = rt; hr[nfr] = highrun;
        end
        nfr++;
        lowrun = 0;
      end
      if (!set_vars) lowrun++;
      prev = set_vars;
    end
    compared++;
    if (nfr !== 3) begin
      mismatched++;
      $display("FAIL b2b_frame_count got %0d expected 3", nfr);
    end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if ({got_e[i], got_w[i], got_t[i]} !== {exp_v[i], exp_v[i], exp_v[i]}) begin
        mismatched++;
        $display("FAIL b2b_value_%0d got %h/%h/%h expected %h", i, got_e[i], got_w[i], got_t[i], exp_v[i]);
      end
      compared++;
      if (hr[i] !== 9) begin
        mismatched++;
        $display("FAIL b2b_high_len_%0d got %0d expected 9", i, hr[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (lr[i] !== 1) begin
        mismatched++;
        $display("FAIL b2b_gap_%0d got %0d expected 1", i, lr[i]);
      end
    end
  endtask

  task automatic test_param();
    logic [5:0] o;
    tau2 = 4'h9; weight2 = 4'h6; thr2 = 4'h0;
    start2 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      start2 = 1'b0;
      o = {set_vars2, expd2, w2, t2, done2, busy2};
      compared++;
      if (o !== exp_p[c]) begin
        mismatched++;
        $display("FAIL param_edge_k+%0d got %b expected %b", c, o, exp_p[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_input_hold();
    test_busy_ignore();
    test_reset_midframe();
    test_back_to_back();
    test_param();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
